// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider for DIV/DIVU issued by EX.
// Produces one quotient bit per cycle and returns {remainder, quotient}
// (hi = remainder, lo = quotient). EX holds start_i until it has consumed
// ready_o; the result stays stable while start_i remains high.
//
// Optional feature: define DIV_SIGNED_EN to honour signed_div_i (DIV).
// Without it every division is unsigned and no sign-fixup logic is built.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   signed_div_i 1 = signed (DIV), 0 = unsigned (DIVU); sampled at start
//   opdata1_i    dividend; sampled at start
//   opdata2_i    divisor; sampled at start
//   start_i      request, held high by EX until the result is consumed
//   annul_i      abort an in-flight division (pipeline flush)
//   result_o     {remainder, quotient}
//   ready_o      result valid
module div #(
    parameter int unsigned DIV_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [DIV_W-1:0]     opdata1_i,
    input  logic [DIV_W-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*DIV_W-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned CNT_W = $clog2(DIV_W + 1);
    localparam int unsigned RES_W = 2 * DIV_W;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   rem_q, rem_d;       // partial remainder
    logic [DIV_W-1:0]   dvd_q, dvd_d;       // dividend shifting out, quotient shifting in
    logic [DIV_W-1:0]   dvs_q, dvs_d;       // divisor magnitude
    logic [RES_W-1:0]   result_q, result_d;
    logic               ready_q, ready_d;

    // Operand magnitudes and final result selection
    logic [DIV_W-1:0]   op1_abs;
    logic [DIV_W-1:0]   op2_abs;
    logic [DIV_W-1:0]   quo_fix;
    logic [DIV_W-1:0]   rem_fix;

`ifdef DIV_SIGNED_EN
    logic               op1_neg;
    logic               op2_neg;
    logic               neg_rem_q, neg_rem_d;   // dividend was negative
    logic               neg_quo_q, neg_quo_d;   // operand signs differ

    assign op1_neg = signed_div_i & opdata1_i[DIV_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DIV_W-1];
    assign op1_abs = op1_neg ? DIV_W'(-opdata1_i) : opdata1_i;
    assign op2_abs = op2_neg ? DIV_W'(-opdata2_i) : opdata2_i;
    assign quo_fix = neg_quo_q ? DIV_W'(-dvd_q) : dvd_q;
    assign rem_fix = neg_rem_q ? DIV_W'(-rem_q) : rem_q;
`else
    logic               unused_signed;

    assign unused_signed = signed_div_i;
    assign op1_abs       = opdata1_i;
    assign op2_abs       = opdata2_i;
    assign quo_fix       = dvd_q;
    assign rem_fix       = rem_q;
`endif

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // The remainder is always below the divisor, so the shifted value fits in
    // DIV_W+1 bits and the difference's top bit is a reliable borrow flag.
    logic [DIV_W:0]     shifted;
    logic [DIV_W:0]     diff;

    assign shifted = {rem_q, dvd_q[DIV_W-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        ready_d   = ready_q;
`ifdef DIV_SIGNED_EN
        neg_rem_d = neg_rem_q;
        neg_quo_d = neg_quo_q;
`endif

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                        cnt_d   = '0;
                        rem_d   = '0;
                        dvd_d   = op1_abs;
                        dvs_d   = op2_abs;
`ifdef DIV_SIGNED_EN
                        neg_rem_d = op1_neg;
                        neg_quo_d = op1_neg ^ op2_neg;
`endif
                    end
                end
            end

            BYZERO: begin
                state_d  = END;
                result_d = '0;
                ready_d  = 1'b1;
            end

            ON: begin
                if (annul_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q == CNT_W'(DIV_W)) begin
                    state_d  = END;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end else begin
                    rem_d = diff[DIV_W] ? shifted[DIV_W-1:0] : diff[DIV_W-1:0];
                    dvd_d = {dvd_q[DIV_W-2:0], ~diff[DIV_W]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            END: begin
                ready_d = 1'b1;
                if (!start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = FREE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

`ifdef DIV_SIGNED_EN
    // Sign flags captured at start for the final fixup
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
        end else begin
            neg_rem_q <= neg_rem_d;
            neg_quo_q <= neg_quo_d;
        end
    end
`endif

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
module tb_div;

    localparam int unsigned W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             signed_div = 1'b0;
    logic [W-1:0]     opdata1 = '0;
    logic [W-1:0]     opdata2 = '0;
    logic             start = 1'b0;
    logic             annul = 1'b0;
    logic [2*W-1:0]   result;
    logic             ready;

    int               checks = 0;
    int               errors = 0;
    logic [2*W-1:0]   exp_q[$];

    always #5 clk = ~clk;

    div #(.DIV_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient}, truncating division, remainder takes dividend sign
    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == '0) return 64'd0;
`ifdef DIV_SIGNED_EN
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {32'(r), 32'(q)};
        end
`else
        if (sgn) begin
            sa = 0;
        end
`endif
        sa = longint'(a);
        sb = longint'(b);
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    // Full handshake: request, latency, result, hold, release
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sgn, input string tag);
        int           lat;
        logic [63:0]  exp_r;
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        exp_q.push_back(model(a, b, sgn));
        @(posedge clk); #1;
        // operands after the start edge must not matter
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = ~sgn;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready && lat < 100);
        check({tag, "_lat"}, 64'(lat), (b == '0) ? 64'd1 : 64'(W + 1));
        exp_r = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check({tag, "_res"}, result, exp_r);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_hold_res"}, result, exp_r);
        check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_clr_rdy"}, 64'(ready), 64'd0);
        check({tag, "_clr_res"}, result, 64'd0);
    endtask

    initial begin
        logic saw;
        int   n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 64'(ready), 64'd0);
        check("rst_res", result, 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Basic unsigned and signed cases
        run_div(32'd100, 32'd7, 1'b0, "u100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2");
        run_div(32'd5, 32'd0, 1'b0, "byzero");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_min_m1");
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "umax_1");
        run_div(32'd0, 32'd5, 1'b1, "zero_5");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s7_m2");

        // Start with annul in FREE is ignored
        opdata1 = 32'd10; opdata2 = 32'd3; start = 1'b1; annul = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        saw = 1'b0;
        repeat (5) begin @(posedge clk); #1; saw |= ready; end
        check("free_annul_rdy", 64'(saw), 64'd0);

        // Annul at iteration 10
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        saw = 1'b0;
        repeat (40) begin @(posedge clk); #1; saw |= ready; end
        check("annul_no_rdy", 64'(saw), 64'd0);
        check("annul_res", result, 64'd0);
        run_div(32'd9, 32'd3, 1'b0, "after_annul");

        // Async reset mid-iteration
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        exp_q.push_back(model(32'd100, 32'd7, 1'b0));
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_rdy", 64'(ready), 64'd0);
        check("rst_mid_res", result, 64'd0);
        exp_q.delete();
        start = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        run_div(32'd1, 32'd1, 1'b0, "post_rst");

        // Async reset while a result is being presented
        opdata1 = 32'd20; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!ready && n < 100) begin @(posedge clk); #1; n++; end
        check("end_rst_pre_res", result, model(32'd20, 32'd3, 1'b0));
        #2;
        rst = 1'b0;
        #1;
        check("end_rst_rdy", 64'(ready), 64'd0);
        check("end_rst_res", result, 64'd0);
        start = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Random operands
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_div(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
